deserializador_4b: RTL and testbench

DESERIALIZADOR_4B -- requirements
Module: deserializador_4b

---
 rtl/deserializador_4b.sv | 91 +++++++++
 tb/tb_deserializador_4b.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/deserializador_4b.sv
// rtl/deserializador_4b.sv - 4-bit serial-to-parallel converter with ready/valid output and sticky overrun.
// Optional build macro DESERIALIZADOR_MSB_FIRST_EN: first received bit lands in o_data[3].
module deserializador_4b (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_dato,
  input  logic       i_valido,
  input  logic       i_limpiar,
  input  logic       i_listo,
  output logic [3:0] o_data,
  output logic       o_valido,
  output logic [1:0] o_indice,
  output logic       o_overrun
);

  logic [3:0] acc_q, acc_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;

  logic [1:0] pos;
  logic [3:0] word_next;
  logic       accept;
  logic       complete;
  logic       transfer;

`ifdef DESERIALIZADOR_MSB_FIRST_EN
  assign pos = 2'd3 - idx_q;
`else
  assign pos = idx_q;
`endif

  assign accept   = i_valido & ~i_limpiar;
  assign complete = accept & (idx_q == 2'd3);
  assign transfer = valid_q & i_listo;

  always_comb begin
    word_next      = acc_q;
    word_next[pos] = i_dato;
  end

  always_comb begin
    acc_d     = acc_q;
    idx_d     = idx_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (i_limpiar) begin
      acc_d = 4'b0000;
      idx_d = 2'd0;
    end else if (accept) begin
      idx_d = idx_q + 2'd1;
      acc_d = complete ? 4'b0000 : word_next;
    end

    // A completing word wins over a simultaneous take; it only overruns when nobody took the old word.
    if (complete) begin
      data_d  = word_next;
      valid_d = 1'b1;
      if (valid_q && !i_listo) begin
        overrun_d = 1'b1;
      end
    end else if (transfer) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q     <= 4'b0000;
      idx_q     <= 2'd0;
      data_q    <= 4'b0000;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_data    = data_q;
  assign o_valido  = valid_q;
  assign o_indice  = idx_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_deserializador_4b.sv
// tb/tb_deserializador_4b.sv - scoreboard bench for deserializador_4b.
module tb_deserializador_4b;

  logic       clk = 1'b0;
  logic       rst, dato, valido, limpiar, listo;
  logic [3:0] data;
  logic       valid_o;
  logic [1:0] indice;
  logic       overrun;

  int errors = 0;
  int checks = 0;
  logic [3:0] sb[$];
  logic [3:0] exp_w;

  deserializador_4b dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_dato    (dato),
    .i_valido  (valido),
    .i_limpiar (limpiar),
    .i_listo   (listo),
    .o_data    (data),
    .o_valido  (valid_o),
    .o_indice  (indice),
    .o_overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    valido = 1'b1;
    dato   = b;
    tick();
    valido = 1'b0;
    dato   = 1'b0;
  endtask

  // Sends word w in the order the active build expects, so o_data should equal w.
  task automatic send_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) begin
`ifdef DESERIALIZADOR_MSB_FIRST_EN
      send_bit(w[3-i]);
`else
      send_bit(w[i]);
`endif
    end
    sb.push_back(w);
  endtask

  task automatic pop_expected(output logic [3:0] w);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected word queued");
      w = 4'bxxxx;
    end else begin
      w = sb.pop_front();
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    checks++; if (data !== 4'b0000) begin errors++; $display("FAIL reset_data: got %b want 0000", data); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    checks++; if (indice !== 2'd0) begin errors++; $display("FAIL reset_indice: got %0d want 0", indice); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_basic_word();
    logic [1:0] exp_idx [4];
    logic [3:0] w;
    exp_idx = '{2'd1, 2'd2, 2'd3, 2'd0};
    w = 4'b1101;
    listo = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef DESERIALIZADOR_MSB_FIRST_EN
      send_bit(w[3-i]);
`else
      send_bit(w[i]);
`endif
      checks++;
      if (indice !== exp_idx[i]) begin errors++; $display("FAIL basic_indice%0d: got %0d want %0d", i, indice, exp_idx[i]); end
    end
    sb.push_back(w);
    pop_expected(exp_w);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", valid_o); end
    checks++; if (data !== exp_w) begin errors++; $display("FAIL basic_data: got %b want %b", data, exp_w); end
    listo = 1'b1;
    tick();
    listo = 1'b0;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL basic_take_valid: got %b want 0", valid_o); end
    checks++; if (data !== exp_w) begin errors++; $display("FAIL basic_take_hold: got %b want %b", data, exp_w); end
  endtask

  task automatic test_gaps();
    logic [3:0] w;
    w = 4'b1101;
    listo = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef DESERIALIZADOR_MSB_FIRST_EN
      send_bit(w[3-i]);
`else
      send_bit(w[i]);
`endif
      tick();
      tick();
      if (i < 3) begin
        checks++;
        if (indice !== 2'(i + 1)) begin errors++; $display("FAIL gap_indice%0d: got %0d want %0d", i, indice, i + 1); end
      end
    end
    sb.push_back(w);
    pop_expected(exp_w);
    checks++; if (valid_o !== 1'b1 || data !== exp_w) begin errors++; $display("FAIL gap_word: got v=%b d=%b want v=1 d=%b", valid_o, data, exp_w); end
    listo = 1'b1;
    tick();
    listo = 1'b0;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL gap_take_valid: got %b want 0", valid_o); end
    checks++; if (data !== exp_w) begin errors++; $display("FAIL gap_take_hold: got %b want %b", data, exp_w); end
  endtask

  task automatic test_overrun();
    listo = 1'b0;
    send_word(4'b0011);
    pop_expected(exp_w);
    checks++; if (data !== exp_w || overrun !== 1'b0) begin errors++; $display("FAIL ovr_first: got d=%b o=%b want d=%b o=0", data, overrun, exp_w); end
    send_word(4'b1010);
    pop_expected(exp_w);
    checks++; if (data !== exp_w) begin errors++; $display("FAIL ovr_data: got %b want %b", data, exp_w); end
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b want 1", valid_o); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", overrun); end
    listo = 1'b1;
    tick();
    listo = 1'b0;
    tick();
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    pulse_reset();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_reset: got %b want 0", overrun); end
  endtask

  task automatic test_limpiar();
    listo = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    valido  = 1'b1;
    dato    = 1'b1;
    limpiar = 1'b1;
    tick();
    valido  = 1'b0;
    limpiar = 1'b0;
    checks++; if (indice !== 2'd0) begin errors++; $display("FAIL clr_indice: got %0d want 0", indice); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL clr_no_word: got %b want 0", valid_o); end
    send_word(4'b1111);
    pop_expected(exp_w);
    checks++; if (data !== exp_w || valid_o !== 1'b1) begin errors++; $display("FAIL clr_data: got d=%b v=%b want d=%b v=1", data, valid_o, exp_w); end
    limpiar = 1'b1;
    listo   = 1'b1;
    tick();
    limpiar = 1'b0;
    listo   = 1'b0;
    checks++; if (valid_o !== 1'b0 || data !== exp_w) begin errors++; $display("FAIL clr_handshake: got v=%b d=%b want v=0 d=%b", valid_o, data, exp_w); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] w;
    listo = 1'b0;
    send_word(4'b0101);
    pop_expected(exp_w);
    checks++; if (data !== exp_w) begin errors++; $display("FAIL b2b_first: got %b want %b", data, exp_w); end
    w = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) listo = 1'b1;
`ifdef DESERIALIZADOR_MSB_FIRST_EN
      send_bit(w[3-i]);
`else
      send_bit(w[i]);
`endif
    end
    listo = 1'b0;
    sb.push_back(w);
    pop_expected(exp_w);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", valid_o); end
    checks++; if (data !== exp_w) begin errors++; $display("FAIL b2b_data: got %b want %b", data, exp_w); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    listo = 1'b1;
    tick();
    listo = 1'b0;
  endtask

  task automatic test_bit_order();
    listo = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
`ifdef DESERIALIZADOR_MSB_FIRST_EN
    sb.push_back(4'b1000);
`else
    sb.push_back(4'b0001);
`endif
    pop_expected(exp_w);
    checks++; if (data !== exp_w) begin errors++; $display("FAIL order_data: got %b want %b", data, exp_w); end
  endtask

  task automatic test_mid_word_reset();
    listo = 1'b1;
    tick();
    listo = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    pulse_reset();
    checks++; if (indice !== 2'd0) begin errors++; $display("FAIL midrst_indice: got %0d want 0", indice); end
    send_word(4'b0100);
    pop_expected(exp_w);
    checks++; if (data !== exp_w) begin errors++; $display("FAIL midrst_data: got %b want %b", data, exp_w); end
  endtask

  initial begin
    rst = 1'b1; dato = 1'b0; valido = 1'b0; limpiar = 1'b0; listo = 1'b0;
    tick();
    test_reset();
    test_basic_word();
    test_gaps();
    test_overrun();
    test_limpiar();
    test_back_to_back();
    test_bit_order();
    test_mid_word_reset();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
